// File: rtl/player_box_renderer.sv
// Per-fencer box renderer: tear-free position updates, 2-stage pixel pipeline, hit-flash FSM.
// Define BOX_OUTLINE_EN to draw only an OUTLINE_W-thick border instead of a solid box.
module player_box_renderer #(
  parameter int          BOX_WIDTH    = 64,
  parameter int          BOX_HEIGHT   = 128,
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 720,
  parameter logic [23:0] BOX_COLOR    = 24'h00FF00,
  parameter logic [23:0] FLASH_COLOR  = 24'hFF0000,
  parameter int          FLASH_FRAMES = 30,
  parameter int          BLINK_PERIOD = 4,
  parameter int          OUTLINE_W    = 4
) (
  input  logic        clk_pixel,
  input  logic        sys_rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        active_draw_in,
  input  logic        new_frame_in,
  input  logic        pos_valid_in,
  input  logic [10:0] pos_x_in,
  input  logic [9:0]  pos_y_in,
  output logic        pos_ready_out,
  input  logic        hit_in,
  output logic [23:0] box_out,
  output logic        flashing_out
);

  // state | meaning
  // IDLE  | no recent hit, box drawn in BOX_COLOR
  // FLASH | hit received, box blinks FLASH_COLOR/BOX_COLOR until FLASH_FRAMES frames pass

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_WIDTH);
  localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - BOX_HEIGHT);
  localparam logic [11:0] BW12  = 12'(BOX_WIDTH);
  localparam logic [11:0] BH12  = 12'(BOX_HEIGHT);
  localparam logic [11:0] OW12  = 12'(OUTLINE_W);
  localparam int          FW    = $clog2(FLASH_FRAMES + 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(FLASH_FRAMES - 1);
`ifdef BOX_OUTLINE_EN
  localparam bit OUTLINE_MODE = 1'b1;
`else
  localparam bit OUTLINE_MODE = 1'b0;
`endif

  typedef enum logic {IDLE, FLASH} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          flashing_q;

  logic          pending_full;
  logic [10:0]   pend_x, act_x, clamp_x;
  logic [9:0]    pend_y, act_y, clamp_y;
  logic          accept;

  logic [11:0]   dx, dy;
  logic          inside_x, inside_y, near_edge, shape_ok;
  logic          inside_x_d, inside_y_d, active_d, shape_d;
  logic          blink_on;
  logic [23:0]   colour;

  // ---------------- position update buffer ----------------
  assign clamp_x       = (pos_x_in > X_MAX) ? X_MAX : pos_x_in;
  assign clamp_y       = (pos_y_in > Y_MAX) ? Y_MAX : pos_y_in;
  assign pos_ready_out = !pending_full;
  assign accept        = pos_valid_in && !pending_full;

  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      pending_full <= 1'b0;
      pend_x       <= '0;
      pend_y       <= '0;
      act_x        <= '0;
      act_y        <= '0;
    end else if (new_frame_in && accept) begin
      act_x        <= clamp_x;
      act_y        <= clamp_y;
      pending_full <= 1'b0;
    end else if (new_frame_in && pending_full) begin
      act_x        <= pend_x;
      act_y        <= pend_y;
      pending_full <= 1'b0;
    end else if (accept) begin
      pend_x       <= clamp_x;
      pend_y       <= clamp_y;
      pending_full <= 1'b1;
    end
  end

  // ---------------- pixel pipeline ----------------
  // A raster coordinate left of/above the box wraps to a huge value, so one compare suffices.
  assign dx        = {1'b0, hcount_in} - {1'b0, act_x};
  assign dy        = {2'b0, vcount_in} - {2'b0, act_y};
  assign inside_x  = dx < BW12;
  assign inside_y  = dy < BH12;
  assign near_edge = (dx < OW12) || (dx >= BW12 - OW12) ||
                     (dy < OW12) || (dy >= BH12 - OW12);
  assign shape_ok  = !OUTLINE_MODE || near_edge;

  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      inside_x_d <= 1'b0;
      inside_y_d <= 1'b0;
      active_d   <= 1'b0;
      shape_d    <= 1'b0;
      box_out    <= '0;
    end else begin
      inside_x_d <= inside_x;
      inside_y_d <= inside_y;
      active_d   <= active_draw_in;
      shape_d    <= shape_ok;
      box_out    <= (inside_x_d && inside_y_d && active_d && shape_d) ? colour : 24'h0;
    end
  end

  assign blink_on = ((int'(fcnt_q) / BLINK_PERIOD) % 2) == 0;
  assign colour   = (state_q == FLASH && blink_on) ? FLASH_COLOR : BOX_COLOR;

  // ---------------- hit-flash FSM ----------------
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      flashing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      flashing_q <= (state_d == FLASH);
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (hit_in) begin
          state_d = FLASH;
          fcnt_d  = '0;
        end
      end
      FLASH: begin
        if (hit_in) begin
          fcnt_d = '0;
        end else if (new_frame_in) begin
          if (fcnt_q == FCNT_LAST) begin
            state_d = IDLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  assign flashing_out = flashing_q;

endmodule

// File: tb/tb_player_box_renderer.sv
// Directed bench for player_box_renderer: position buffering, clamp, pipeline latency, hit flash.
module tb_player_box_renderer;

  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] RED   = 24'hFF0000;

  logic        clk_pixel = 1'b0;
  logic        sys_rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        active_draw_in;
  logic        new_frame_in;
  logic        pos_valid_in;
  logic [10:0] pos_x_in;
  logic [9:0]  pos_y_in;
  logic        pos_ready_out;
  logic        hit_in;
  logic [23:0] box_out;
  logic        flashing_out;

  int tests_run = 0;
  int tests_failed = 0;

  player_box_renderer dut (
    .clk_pixel      (clk_pixel),
    .sys_rst        (sys_rst),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .active_draw_in (active_draw_in),
    .new_frame_in   (new_frame_in),
    .pos_valid_in   (pos_valid_in),
    .pos_x_in       (pos_x_in),
    .pos_y_in       (pos_y_in),
    .pos_ready_out  (pos_ready_out),
    .hit_in         (hit_in),
    .box_out        (box_out),
    .flashing_out   (flashing_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic ad,
                     input logic [23:0] exp);
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    active_draw_in = ad;
    tick();
    tick();
    check(tag, box_out, exp);
  endtask

  task automatic frame_pulse();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  task automatic send_pos(input int x, input int y);
    pos_x_in     = 11'(x);
    pos_y_in     = 10'(y);
    pos_valid_in = 1'b1;
    tick();
    pos_valid_in = 1'b0;
  endtask

  function automatic logic [23:0] flash_colour(input int f);
    return ((f / 4) % 2 == 0) ? RED : GREEN;
  endfunction

  initial begin
    sys_rst = 1'b1; hcount_in = '0; vcount_in = '0; active_draw_in = 1'b0;
    new_frame_in = 1'b0; pos_valid_in = 1'b0; pos_x_in = '0; pos_y_in = '0; hit_in = 1'b0;
    tick(); tick();
    check("rst_box", box_out, 24'h0);
    check("rst_flash", {23'h0, flashing_out}, 24'h1 & 24'h0);
    check("rst_ready", {23'h0, pos_ready_out}, 24'h1);
    sys_rst = 1'b0;

    // box at (0,0)
    pix("p00", 0, 0, 1'b1, GREEN);
    pix("p63_127", 63, 127, 1'b1, GREEN);
    pix("p64_0", 64, 0, 1'b1, 24'h0);
    pix("p0_128", 0, 128, 1'b1, 24'h0);
    pix("p2_10", 2, 10, 1'b1, GREEN);
    pix("blank", 2, 10, 1'b0, 24'h0);

    // latency: (63,127) appears exactly two edges after it is presented
    pix("lat_pre", 100, 0, 1'b1, 24'h0);
    hcount_in = 11'd63; vcount_in = 10'd127; tick();
    check("lat_n1", box_out, 24'h0);
    hcount_in = 11'd64; tick();
    check("lat_n2", box_out, GREEN);
    tick();
    check("lat_n3", box_out, 24'h0);

    // mid-frame accept is held until frame start
    send_pos(500, 300);
    check("pend_ready", {23'h0, pos_ready_out}, 24'h0);
    pix("old_pos", 2, 10, 1'b1, GREEN);
    pix("not_yet", 500, 300, 1'b1, 24'h0);
    frame_pulse();
    check("commit_ready", {23'h0, pos_ready_out}, 24'h1);
    pix("new_tl", 500, 300, 1'b1, GREEN);
    pix("new_br", 563, 427, 1'b1, GREEN);
    pix("new_right", 564, 300, 1'b1, 24'h0);
    pix("new_left", 499, 300, 1'b1, 24'h0);
    pix("old_gone", 2, 10, 1'b1, 24'h0);

    // second accept stalls while the slot is full
    send_pos(100, 50);
    pos_x_in = 11'd200; pos_y_in = 10'd60; pos_valid_in = 1'b1;
    tick();
    check("stall_ready", {23'h0, pos_ready_out}, 24'h0);
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
    check("stall_rel", {23'h0, pos_ready_out}, 24'h1);
    pos_valid_in = 1'b0;
    pix("first_wins", 100, 50, 1'b1, GREEN);
    pix("second_no", 200, 60, 1'b1, 24'h0);

    // accept on the frame-start cycle commits directly
    pos_x_in = 11'd300; pos_y_in = 10'd200; pos_valid_in = 1'b1; new_frame_in = 1'b1;
    tick();
    pos_valid_in = 1'b0; new_frame_in = 1'b0;
    check("direct_ready", {23'h0, pos_ready_out}, 24'h1);
    pix("direct_pos", 300, 200, 1'b1, GREEN);
    pix("direct_prev", 100, 50, 1'b1, 24'h0);

    // clamp (1270,700) -> (1216,592)
    send_pos(1270, 700);
    frame_pulse();
    pix("clamp_br", 1279, 719, 1'b1, GREEN);
    pix("clamp_tl", 1216, 592, 1'b1, GREEN);
    pix("clamp_l", 1215, 592, 1'b1, 24'h0);
    pix("clamp_t", 1216, 591, 1'b1, 24'h0);

    // hit flash
    hit_in = 1'b1; tick(); hit_in = 1'b0;
    check("hit_flag", {23'h0, flashing_out}, 24'h1);
    pix("hit_f0", 1279, 719, 1'b1, RED);
    for (int f = 1; f <= 10; f++) begin
      frame_pulse();
      pix($sformatf("flash_f%0d", f), 1279, 719, 1'b1, flash_colour(f));
    end
    hit_in = 1'b1; tick(); hit_in = 1'b0;
    pix("retrig_f0", 1279, 719, 1'b1, RED);
    for (int f = 1; f <= 29; f++) begin
      frame_pulse();
      if (f % 4 == 0 || f == 29)
        pix($sformatf("re_f%0d", f), 1279, 719, 1'b1, flash_colour(f));
    end
    check("f29_flag", {23'h0, flashing_out}, 24'h1);
    // hit on the exit frame keeps flashing
    hit_in = 1'b1; new_frame_in = 1'b1; tick(); hit_in = 1'b0; new_frame_in = 1'b0;
    check("hit_beats_exit", {23'h0, flashing_out}, 24'h1);
    pix("hbe_f0", 1279, 719, 1'b1, RED);
    for (int f = 1; f <= 29; f++) frame_pulse();
    check("end_f29", {23'h0, flashing_out}, 24'h1);
    frame_pulse();
    check("exit_flag", {23'h0, flashing_out}, 24'h0);
    pix("exit_colour", 1279, 719, 1'b1, GREEN);

    // reset mid-flash aborts
    hit_in = 1'b1; tick(); hit_in = 1'b0;
    check("pre_rst_flag", {23'h0, flashing_out}, 24'h1);
    sys_rst = 1'b1; tick();
    check("midrst_flag", {23'h0, flashing_out}, 24'h0);
    check("midrst_box", box_out, 24'h0);
    sys_rst = 1'b0;
    pix("midrst_pos", 0, 0, 1'b1, GREEN);
    pix("midrst_old", 1279, 719, 1'b1, 24'h0);

    // outline vs solid interior
    pos_x_in = 11'd100; pos_y_in = 10'd100; pos_valid_in = 1'b1; new_frame_in = 1'b1;
    tick();
    pos_valid_in = 1'b0; new_frame_in = 1'b0;
    pix("edge_102", 102, 150, 1'b1, GREEN);
`ifdef BOX_OUTLINE_EN
    pix("interior_110", 110, 150, 1'b1, 24'h0);
    pix("edge_104", 104, 150, 1'b1, 24'h0);
`else
    pix("interior_110", 110, 150, 1'b1, GREEN);
    pix("interior_104", 104, 150, 1'b1, GREEN);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
